// File: rtl/tick_sched_pkg.sv
// Shared types and constants for the tick_sched clock-enable scheduler.
// Channel 0 defaults to a 25 MHz square wave and channel 1 to 1 kHz.
package tick_sched_pkg;

   typedef enum logic {
      STOP = 1'b0,
      RUN  = 1'b1
   } state_e;

   localparam int DIV_W    = 20;
   localparam int DIV0_RST = 2;
   localparam int DIV1_RST = 50000;
   localparam int MAX_CH   = 4;
   localparam int CH_W     = 2;

   // Only channels 0 and 1 start out enabled.
   function automatic int rstDiv(input int ch, input int d0, input int d1);
      return (ch == 0) ? d0 : ((ch == 1) ? d1 : 0);
   endfunction

endpackage

// File: rtl/tick_sched_if.sv
// Configuration write port of tick_sched.
// It is a valid/ready handshake that selects a channel and carries a new divisor.
interface tick_sched_if
   import tick_sched_pkg::*;
#(
   parameter int DIV_W = tick_sched_pkg::DIV_W
) ();

   logic             cfg_valid;
   logic             cfg_ready;
   logic [CH_W-1:0]  cfg_ch;
   logic [DIV_W-1:0] cfg_div;

   modport master (
      output cfg_valid,
      output cfg_ch,
      output cfg_div,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid,
      input  cfg_ch,
      input  cfg_div,
      output cfg_ready
   );

endinterface

// File: rtl/tick_sched_chan.sv
// One divider channel.
// Holds the divisor, the shadowed retune request, the period counter and the tick/square outputs.
module tick_chan
   import tick_sched_pkg::*;
#(
   parameter int               DIV_W   = tick_sched_pkg::DIV_W,
   parameter logic [DIV_W-1:0] RST_DIV = '0
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             runEn_i,
   input  logic             start_i,
   input  logic             stop_i,
   input  logic             wr_i,
   input  logic [DIV_W-1:0] wrDiv_i,
   output logic             tick_o,
   output logic             sq_o,
   output logic             pend_o,
   output logic             pendNext_o
);

   localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

   logic [DIV_W-1:0] div_q, div_d;
   logic [DIV_W-1:0] shadow_q, shadow_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic             pend_q, pend_d;
   logic             tick_q, tick_d;
   logic             sq_q, sq_d;
   logic             enabled;
   logic             atEnd;

   assign enabled = (div_q != '0);
   assign atEnd   = (cnt_q == (div_q - ONE));

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         div_q    <= RST_DIV;
         shadow_q <= '0;
         cnt_q    <= '0;
         pend_q   <= 1'b0;
         tick_q   <= 1'b0;
         sq_q     <= 1'b0;
      end else begin
         div_q    <= div_d;
         shadow_q <= shadow_d;
         cnt_q    <= cnt_d;
         pend_q   <= pend_d;
         tick_q   <= tick_d;
         sq_q     <= sq_d;
      end
   end

   // The square wave follows the registered tick.
   // Its edges therefore land one cycle after each tick.
   always_comb begin
      div_d    = div_q;
      shadow_d = shadow_q;
      cnt_d    = cnt_q;
      pend_d   = pend_q;
      tick_d   = 1'b0;
      sq_d     = sq_q ^ tick_q;

      if (start_i) begin
         cnt_d = '0;
         sq_d  = 1'b0;
      end else if (stop_i) begin
         if (pend_q) begin
            div_d  = shadow_q;
            pend_d = 1'b0;
         end
      end else if (runEn_i && enabled) begin
         if (atEnd) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            if (pend_q) begin
               div_d  = shadow_q;
               pend_d = 1'b0;
            end
         end else begin
            cnt_d = cnt_q + ONE;
         end
      end

      // A retune is shadowed while the channel is counting.
      // This lets the current period finish untouched.
      if (wr_i) begin
         if (runEn_i && enabled) begin
            shadow_d = wrDiv_i;
            pend_d   = 1'b1;
         end else begin
            div_d = wrDiv_i;
            if (runEn_i) begin
               cnt_d = '0;
            end
         end
      end
   end

   assign tick_o     = tick_q;
   assign sq_o       = sq_q;
   assign pend_o     = pend_q;
   assign pendNext_o = pend_d;

endmodule

// File: rtl/tick_sched.sv
// Programmable clock-enable scheduler.
// It drives up to four divided tick strobes and square waves, and each channel can be retuned without glitches.
module tick_sched
   import tick_sched_pkg::*;
#(
   parameter int N_CH     = 4,
   parameter int DIV_W    = tick_sched_pkg::DIV_W,
   parameter int DIV0_RST = tick_sched_pkg::DIV0_RST,
   parameter int DIV1_RST = tick_sched_pkg::DIV1_RST
) (
   input  logic            clk_in_100M,
   input  logic            rst_n,
   input  logic            run,
   tick_sched_if.slave     cfg,
   output logic [N_CH-1:0] tick,
   output logic [N_CH-1:0] sq_out,
   output logic            busy
);

   state_e          state_q, state_d;
   logic            startEdge;
   logic            stopEdge;
   logic            runEn;
   logic            cfgReady;
   logic            accept;
   logic [N_CH-1:0] wrSel;
   logic [N_CH-1:0] pend;
   logic [N_CH-1:0] pendNext;
   logic            busy_q;

   always_ff @(posedge clk_in_100M or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= STOP;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= |pendNext;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         STOP:    if (run)  state_d = RUN;
         RUN:     if (!run) state_d = STOP;
         default: state_d = STOP;
      endcase
   end

   assign startEdge = (state_q == STOP) && run;
   assign stopEdge  = (state_q == RUN) && !run;
   assign runEn     = (state_q == RUN) && run;

   // Writes to channel numbers that do not exist are accepted and then dropped.
   always_comb begin
      cfgReady = 1'b1;
      wrSel    = '0;
      for (int c = 0; c < N_CH; c++) begin
         if (cfg.cfg_ch == CH_W'(c)) begin
            cfgReady = ~pend[c];
         end
      end
      accept = cfg.cfg_valid & cfgReady;
      for (int c = 0; c < N_CH; c++) begin
         if (accept && (cfg.cfg_ch == CH_W'(c))) begin
            wrSel[c] = 1'b1;
         end
      end
   end

   assign cfg.cfg_ready = cfgReady;
   assign busy          = busy_q;

   for (genvar c = 0; c < N_CH; c++) begin : gChan
      tick_chan #(
         .DIV_W   (DIV_W),
         .RST_DIV (DIV_W'(rstDiv(c, DIV0_RST, DIV1_RST)))
      ) uChan (
         .clk_i      (clk_in_100M),
         .rst_n_i    (rst_n),
         .runEn_i    (runEn),
         .start_i    (startEdge),
         .stop_i     (stopEdge),
         .wr_i       (wrSel[c]),
         .wrDiv_i    (cfg.cfg_div),
         .tick_o     (tick[c]),
         .sq_o       (sq_out[c]),
         .pend_o     (pend[c]),
         .pendNext_o (pendNext[c])
      );
   end

endmodule

// File: tb/tb_tick_sched.sv
// Self-checking bench for tick_sched.
// An absolute-edge-time model checks the outputs every cycle, and directed scenarios add hand-computed checks.
module tb_tick_sched;
   import tick_sched_pkg::*;

   localparam int NCH = 4;
   localparam int D0  = 2;
   localparam int D1  = 60;

   logic           clk   = 1'b0;
   logic           rst_n = 1'b0;
   logic           run   = 1'b0;
   logic [NCH-1:0] tick;
   logic [NCH-1:0] sqOut;
   logic           busy;

   tick_sched_if #(.DIV_W(DIV_W)) cfgIf ();

   tick_sched #(
      .N_CH     (NCH),
      .DIV_W    (DIV_W),
      .DIV0_RST (D0),
      .DIV1_RST (D1)
   ) dut (
      .clk_in_100M (clk),
      .rst_n       (rst_n),
      .run         (run),
      .cfg         (cfgIf),
      .tick        (tick),
      .sq_out      (sqOut),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int nTotal = 0;
   int nPass  = 0;
   int cyc    = 0;
   bit chkOn  = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Each channel remembers the absolute edge of its next wrap.
   // It does not track a running count.
   int edgeN;
   bit runM;
   int divM   [NCH];
   int shadM  [NCH];
   int wrapAt [NCH];
   bit pendM  [NCH];
   bit tickM  [NCH];
   bit sqM    [NCH];

   function automatic void modelReset();
      edgeN = 0;
      runM  = 1'b0;
      for (int c = 0; c < NCH; c++) begin
         divM[c]   = (c == 0) ? D0 : ((c == 1) ? D1 : 0);
         shadM[c]  = 0;
         wrapAt[c] = 0;
         pendM[c]  = 1'b0;
         tickM[c]  = 1'b0;
         sqM[c]    = 1'b0;
      end
   endfunction

   function automatic void modelStep();
      int ch;
      int nd;
      bit acc;
      bit goRun;
      bit goStop;
      bit inRun;
      ch     = int'(cfgIf.cfg_ch);
      nd     = int'(cfgIf.cfg_div);
      acc    = cfgIf.cfg_valid && !pendM[ch];
      goRun  = !runM && run;
      goStop = runM && !run;
      inRun  = runM && run;
      edgeN++;
      for (int c = 0; c < NCH; c++) begin
         sqM[c]   = sqM[c] ^ tickM[c];
         tickM[c] = 1'b0;
         if (goStop && pendM[c]) begin
            divM[c]  = shadM[c];
            pendM[c] = 1'b0;
         end
         if (inRun && divM[c] != 0 && wrapAt[c] == edgeN) begin
            tickM[c] = 1'b1;
            if (pendM[c]) begin
               divM[c]  = shadM[c];
               pendM[c] = 1'b0;
            end
            wrapAt[c] = edgeN + divM[c];
         end
      end
      if (acc) begin
         if (inRun && divM[ch] != 0) begin
            shadM[ch] = nd;
            pendM[ch] = 1'b1;
         end else begin
            divM[ch]   = nd;
            wrapAt[ch] = edgeN + nd;
         end
      end
      if (goRun) begin
         for (int c = 0; c < NCH; c++) begin
            sqM[c]    = 1'b0;
            wrapAt[c] = edgeN + divM[c];
         end
      end
      runM = goRun | inRun;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) modelReset();
      else        modelStep();
   end

   task automatic checkVal(input string name, input int got, input int want);
      nTotal++;
      if (got == want) nPass++;
      else $display("[TB] FAIL %s: got %0d want %0d (cycle %0d)", name, got, want, cyc);
   endtask

   task automatic checkOutput();
      logic [NCH-1:0] expTick;
      logic [NCH-1:0] expSq;
      bit             expBusy;
      expBusy = 1'b0;
      for (int c = 0; c < NCH; c++) begin
         expTick[c] = tickM[c];
         expSq[c]   = sqM[c];
         expBusy    = expBusy | pendM[c];
      end
      checkVal("model tick", int'(tick), int'(expTick));
      checkVal("model sq_out", int'(sqOut), int'(expSq));
      checkVal("model busy", int'(busy), int'(expBusy));
      checkVal("model cfg_ready", int'(cfgIf.cfg_ready), int'(!pendM[int'(cfgIf.cfg_ch)]));
   endtask

   int lastTick [NCH];
   int prevTick [NCH];

   initial begin
      for (int c = 0; c < NCH; c++) begin
         lastTick[c] = 0;
         prevTick[c] = 0;
      end
      forever begin
         @(posedge clk);
         #1;
         if (chkOn) checkOutput();
         for (int c = 0; c < NCH; c++) begin
            if (tick[c]) begin
               prevTick[c] = lastTick[c];
               lastTick[c] = cyc;
            end
         end
      end
   end

   task automatic applyStimulus(input int ch, input int dv);
      int waited;
      bit done;
      waited = 0;
      done   = 1'b0;
      @(negedge clk);
      cfgIf.cfg_valid = 1'b1;
      cfgIf.cfg_ch    = CH_W'(ch);
      cfgIf.cfg_div   = DIV_W'(dv);
      while (!done && waited < 200) begin
         if (cfgIf.cfg_ready) begin
            @(posedge clk);
            done = 1'b1;
         end
         @(negedge clk);
         waited++;
      end
      cfgIf.cfg_valid = 1'b0;
      if (!done) checkVal("cfg accept timeout", 0, 1);
   endtask

   task automatic waitTick(input int ch, output int at);
      at = -1;
      for (int i = 0; i < 300 && at < 0; i++) begin
         @(posedge clk);
         #1;
         if (tick[ch]) at = cyc;
      end
      if (at < 0) checkVal("tick wait timeout", 0, 1);
   endtask

   int t0;
   int t1;
   int t2;
   int seen;
   logic [NCH-1:0] sqHold;

   initial begin
      cfgIf.cfg_valid = 1'b0;
      cfgIf.cfg_ch    = '0;
      cfgIf.cfg_div   = '0;
      chkOn = 1'b1;
      repeat (3) @(negedge clk);
      checkVal("reset tick", int'(tick), 0);
      rst_n = 1'b1;
      @(negedge clk);
      checkVal("reset sq_out", int'(sqOut), 0);
      checkVal("reset busy", int'(busy), 0);
      checkVal("reset cfg_ready", int'(cfgIf.cfg_ready), 1);

      run = 1'b1;
      @(posedge clk); #1;
      checkVal("entry tick0", int'(tick[0]), 0);
      @(posedge clk); #1;
      checkVal("edge1 tick0", int'(tick[0]), 0);
      @(posedge clk); #1;
      checkVal("edge2 tick0", int'(tick[0]), 1);
      @(posedge clk); #1;
      checkVal("edge3 sq0", int'(sqOut[0]), 1);
      checkVal("edge3 tick0", int'(tick[0]), 0);
      waitTick(1, t0);
      waitTick(1, t1);
      checkVal("ch1 default gap", t1 - t0, D1);
      checkVal("ch2/3 idle", int'(tick[3:2]), 0);

      @(negedge clk);
      run = 1'b0;
      repeat (3) @(negedge clk);
      applyStimulus(2, 1);
      applyStimulus(3, 0);
      run = 1'b1;
      @(posedge clk); #1;
      checkVal("div1 entry tick2", int'(tick[2]), 0);
      @(posedge clk); #1;
      checkVal("div1 e1 tick2", int'(tick[2]), 1);
      checkVal("div1 e1 sq2", int'(sqOut[2]), 0);
      @(posedge clk); #1;
      checkVal("div1 e2 tick2", int'(tick[2]), 1);
      checkVal("div1 e2 sq2", int'(sqOut[2]), 1);
      @(posedge clk); #1;
      checkVal("div1 e3 sq2", int'(sqOut[2]), 0);
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         seen = seen | int'(tick[3]);
      end
      checkVal("div0 tick3 never", seen, 0);

      applyStimulus(0, 5);
      checkVal("retune busy", int'(busy), 1);
      cfgIf.cfg_valid = 1'b1;
      cfgIf.cfg_ch    = '0;
      cfgIf.cfg_div   = DIV_W'(7);
      checkVal("retune ready0", int'(cfgIf.cfg_ready), 0);
      @(negedge clk);
      cfgIf.cfg_valid = 1'b0;
      repeat (20) @(negedge clk);
      checkVal("retune gap", lastTick[0] - prevTick[0], 5);
      checkVal("retune busy clear", int'(busy), 0);

      waitTick(1, t0);
      repeat (59) @(posedge clk);
      @(negedge clk);
      cfgIf.cfg_valid = 1'b1;
      cfgIf.cfg_ch    = CH_W'(1);
      cfgIf.cfg_div   = DIV_W'(10);
      @(negedge clk);
      cfgIf.cfg_valid = 1'b0;
      checkVal("wrap accept busy", int'(busy), 1);
      waitTick(1, t1);
      checkVal("wrap accept old period", t1 - t0, 2 * D1);
      waitTick(1, t2);
      checkVal("wrap accept new gap", t2 - t1, 10);
      checkVal("wrap accept busy clear", int'(busy), 0);

      applyStimulus(0, 2);
      run = 1'b0;
      @(posedge clk); #1;
      checkVal("stop applies pending", int'(busy), 0);
      sqHold = sqOut;
      seen   = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         seen = seen | int'(tick);
      end
      checkVal("stop no ticks", seen, 0);
      checkVal("stop sq hold", int'(sqOut), int'(sqHold));
      @(negedge clk);
      run = 1'b1;
      @(posedge clk); #1;
      checkVal("restart sq clear", int'(sqOut), 0);
      @(posedge clk); #1;
      checkVal("restart e1 tick0", int'(tick[0]), 0);
      @(posedge clk); #1;
      checkVal("restart e2 tick0", int'(tick[0]), 1);

      applyStimulus(0, 9);
      checkVal("pre-reset busy", int'(busy), 1);
      #2;
      rst_n = 1'b0;
      run   = 1'b0;
      #1;
      checkVal("async reset tick", int'(tick), 0);
      checkVal("async reset sq", int'(sqOut), 0);
      checkVal("async reset busy", int'(busy), 0);
      checkVal("async reset ready", int'(cfgIf.cfg_ready), 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checkVal("post-reset e1 tick0", int'(tick[0]), 0);
      @(posedge clk); #1;
      checkVal("post-reset e2 tick0", int'(tick[0]), 1);
      checkVal("post-reset busy", int'(busy), 0);
      waitTick(1, t0);
      waitTick(1, t1);
      checkVal("post-reset ch1 gap", t1 - t0, D1);

      repeat (2) @(negedge clk);
      chkOn = 1'b0;
      $display("%0d/%0d checks passed", nPass, nTotal);
      $finish;
   end

endmodule

// File: doc/tick_sched.md
# tick_sched

Programmable clock-enable scheduler for the MCU clock domain. It runs from the 100 MHz board clock and produces up to four independent divided tick strobes and square-wave outputs. Divisors are written through a valid/ready configuration port. Writes made while running are shadowed and applied only at the channel's next period boundary, so retuning never produces a runt pulse. It replaces fixed free-running dividers and drives display, timer and peripheral clock enables.

## Interface
- `N_CH`, 4: number of channels (1..4).
- `DIV_W`, 20: divisor width.
- `DIV0_RST`, 2: channel 0 reset divisor (25 MHz square).
- `DIV1_RST`, 50000: channel 1 reset divisor (1 kHz square).
- `clk_in_100M`  in  1: single clock, 100 MHz.
- `rst_n`  in  1: asynchronous, active-low reset.
- `run`  in  1: level; 1 = run, 0 = stop.
- `cfg_valid`  in  1: configuration write request.
- `cfg_ready`  out  1: write can be accepted.
- `cfg_ch`  in  2: target channel.
- `cfg_div`  in  DIV_W: new divisor; 0 disables the channel.
- `tick`  out  N_CH: one-cycle strobe per period.
- `sq_out`  out  N_CH: square wave that toggles on each tick.
- `busy`  out  1: some channel has a pending (shadowed) divisor.

## Operation
- **Reset values:** tick=0, sq_out=0, busy=0, cfg_ready=1.
  - Divisors: ch0=DIV0_RST, ch1=DIV1_RST, others=0.
  - Counters=0, FSM=STOP.
- **FSM states:**
  - STOP → RUN when run=1 is sampled. The entry edge clears all counters and all sq_out bits.
  - RUN → STOP when run=0 is sampled.
  - In STOP, counters freeze, tick=0, and sq_out holds its value.
- **Channel counting (RUN, div≠0):**
  - Counter counts 0..div-1.
  - When count==div-1, tick is high that cycle, count wraps to 0, and sq_out toggles.
  - sq_out period = 2·div cycles.
  - div=1: tick is high every cycle and sq_out toggles every cycle.
- **Disabled channel (div=0):** counter held at 0, tick=0, sq_out holds.
- **Handshake:**
  - A write is accepted on cfg_valid & cfg_ready.
  - cfg_ready = ~pending[cfg_ch] (combinational from cfg_ch).
  - cfg_ch ≥ N_CH: accepted and ignored.
- **Applying a write:**
  - STOP: the divisor is updated on the accept edge.
  - RUN, channel disabled: the divisor is updated on the accept edge and the count restarts at 0.
  - RUN, channel enabled: the write is stored as pending. It is applied on the channel's next wrap edge, and the following period uses the new divisor.
  - Accept and wrap in the same cycle: the write stays pending until the next wrap.
- **Pending writes across STOP:** a pending write whose target channel enters STOP is applied on the STOP-entry edge.
- **busy** = OR of all pending flags, registered.
- **Reset mid-operation:** everything returns to reset values immediately (asynchronous). All pending writes are discarded.

## Timing
- All outputs are registered. The only exception is cfg_ready, which is combinational from cfg_ch and pending.
- **First tick after RUN entry:** the RUN-entry edge is edge 0, and the first tick is asserted after edge div. The first sq_out rise occurs on edge div+1.
- **Tick spacing:** exactly div cycles between ticks, with no jitter.
- **Retune:** the old period completes in full. The first new-length period starts on the wrap edge.
- **Pending flag:** set on the accept edge, cleared on the apply edge. cfg_ready for that channel returns to 1 the following cycle.

## Structure
- **Package `tick_sched_pkg`:**
  - State enum {STOP, RUN}.
  - DIV_W.
  - Default divisor constants.
  - Channel-index width.
- **Sub-module `tick_chan`,** instantiated N_CH times. It contains:
  - divisor register
  - shadow register and pending flag
  - counter
  - tick/sq_out generation
- **Top level:** FSM, cfg decode and cfg_ready mux, busy reduction.

## Test plan
- **Reset defaults:** release rst_n, set run=1.
  - Expect sq_out[0] with a 4-cycle period and sq_out[1] with a 100000-cycle period (1 kHz).
  - Expect tick[2:3]=0 and busy=0.
- **div=1 and div=0:** in STOP, write ch2 div=1 and ch3 div=0, then run.
  - Expect tick[2] high every cycle and sq_out[2] toggling every cycle.
  - Expect tick[3] never asserted.
- **Shadowed retune:** in RUN, write ch0 div=5 mid-period.
  - Expect busy=1 and cfg_ready=0 for ch0, and a second write to ch0 stalled.
  - The current 2-cycle period completes, then ticks are 5 cycles apart.
  - Expect busy=0 after the apply edge.
- **Accept-on-wrap corner:** write ch1 div=10 in the same cycle as a ch1 tick.
  - Expect one more full 50000-cycle period, then 10-cycle ticks.
- **Stop/restart:** drop run for 7 cycles, then raise it.
  - Expect ticks to stop and sq_out to hold.
  - On restart, expect counters and sq_out cleared, and the first ch0 tick on edge 2 after entry.
- **Reset mid-operation:** assert rst_n low with ch0 pending at div=9.
  - Expect outputs to clear immediately.
  - After release, expect divisors back at defaults and no pending write.
